// File: rtl/note_sequencer.sv
// note_sequencer: plays period/duration steps from a small memory as signed
// square-wave samples over a valid/ready stream, with optional silent gaps.
module note_sequencer #(
  parameter int width_p        = 12,
  parameter int steps_p        = 16,
  parameter int period_width_p = 12,
  parameter int dur_width_p    = 16,
  parameter int gap_samples_p  = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         wr_en_i,
  input  logic [$clog2(steps_p)-1:0]   wr_addr_i,
  input  logic [period_width_p-1:0]    wr_period_i,
  input  logic [dur_width_p-1:0]       wr_dur_i,
  input  logic [$clog2(steps_p):0]     len_i,
  input  logic                         loop_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         ready_i,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic [$clog2(steps_p)-1:0]   step_o,
  output logic                         done_o
);

  localparam int sw_lp = $clog2(steps_p);
  localparam int lw_lp = sw_lp + 1;
  localparam int gw_lp = (gap_samples_p > 1) ? $clog2(gap_samples_p + 1) : 1;

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] note_s = 2'd1;
  localparam logic [1:0] gap_s  = 2'd2;

  localparam logic [width_p-1:0] amp_lp     = {1'b0, {(width_p-1){1'b1}}};
  localparam logic [width_p-1:0] neg_amp_lp = {1'b1, {(width_p-2){1'b0}}, 1'b1};

  logic [period_width_p-1:0] per_mem [steps_p];
  logic [dur_width_p-1:0]    dur_mem [steps_p];

  logic [1:0]                state_r, state_n;
  logic [lw_lp-1:0]          len_r, len_n;
  logic                      loop_r, loop_n;
  logic [sw_lp-1:0]          step_n;
  logic [period_width_p-1:0] period_r, period_n, ph_r, ph_n;
  logic [dur_width_p-1:0]    dur_r, dur_n, dc_r, dc_n;
  logic [gw_lp-1:0]          gc_r, gc_n;
  logic [width_p-1:0]        data_n;
  logic                      done_n, adv, load, hs;

  assign hs = valid_o & ready_i;

  // Memory is not reset; a same-cycle write is seen by the next load only.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      per_mem[wr_addr_i] <= wr_period_i;
      dur_mem[wr_addr_i] <= wr_dur_i;
    end
  end

  always_comb begin
    state_n  = state_r;
    len_n    = len_r;
    loop_n   = loop_r;
    step_n   = step_o;
    period_n = period_r;
    dur_n    = dur_r;
    ph_n     = ph_r;
    dc_n     = dc_r;
    gc_n     = gc_r;
    done_n   = 1'b0;
    adv      = 1'b0;
    load     = 1'b0;

    if (stop_i) begin
      state_n = idle_s;
      ph_n    = '0;
      dc_n    = '0;
      gc_n    = '0;
    end else begin
      case (state_r)
        idle_s: begin
          if (start_i && (len_i != '0)) begin
            len_n   = (len_i > lw_lp'(steps_p)) ? lw_lp'(steps_p) : len_i;
            loop_n  = loop_i;
            step_n  = '0;
            load    = 1'b1;
            state_n = note_s;
          end
        end
        note_s: begin
          if (hs) begin
            ph_n = (ph_r == period_r - period_width_p'(1)) ? '0 : ph_r + period_width_p'(1);
            dc_n = dc_r + dur_width_p'(1);
            if (dc_n == dur_r) begin
              if (gap_samples_p > 0) begin
                state_n = gap_s;
                gc_n    = '0;
              end else begin
                adv = 1'b1;
              end
            end
          end
        end
        gap_s: begin
          if (hs) begin
            gc_n = gc_r + gw_lp'(1);
            if (gc_n == gw_lp'(gap_samples_p)) adv = 1'b1;
          end
        end
        default: state_n = idle_s;
      endcase

      if (adv) begin
        if (({1'b0, step_o} + lw_lp'(1)) < len_r) begin
          step_n  = step_o + sw_lp'(1);
          load    = 1'b1;
          state_n = note_s;
        end else if (loop_r) begin
          step_n  = '0;
          load    = 1'b1;
          state_n = note_s;
        end else begin
          state_n = idle_s;
          done_n  = 1'b1;
        end
      end

      if (load) begin
        period_n = per_mem[step_n];
        dur_n    = (dur_mem[step_n] == '0) ? dur_width_p'(1) : dur_mem[step_n];
        ph_n     = '0;
        dc_n     = '0;
      end
    end

    // Output sample is computed from the next state so data_o is a register.
    data_n = '0;
    if ((state_n == note_s) && (period_n != '0))
      data_n = (ph_n < (period_n >> 1)) ? amp_lp : neg_amp_lp;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r  <= idle_s;
      len_r    <= '0;
      loop_r   <= 1'b0;
      period_r <= '0;
      dur_r    <= '0;
      ph_r     <= '0;
      dc_r     <= '0;
      gc_r     <= '0;
      step_o   <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_r  <= state_n;
      len_r    <= len_n;
      loop_r   <= loop_n;
      period_r <= period_n;
      dur_r    <= dur_n;
      ph_r     <= ph_n;
      dc_r     <= dc_n;
      gc_r     <= gc_n;
      step_o   <= step_n;
      data_o   <= data_n;
      valid_o  <= 1'b1;
      busy_o   <= (state_n != idle_s);
      done_o   <= done_n;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one instance without gaps, one with a
// two-sample gap, sharing all inputs.
module tb_note_sequencer;

  logic        clk_i, reset_ni, wr_en_i, loop_i, start_i, stop_i, ready_i;
  logic [3:0]  wr_addr_i;
  logic [11:0] wr_period_i;
  logic [15:0] wr_dur_i;
  logic [4:0]  len_i;

  logic [11:0] data0, data2;
  logic        valid0, valid2, busy0, busy2, done0, done2;
  logic [3:0]  step0, step2;

  int n_checks = 0;
  int n_fail   = 0;

  note_sequencer #(.width_p(12), .steps_p(16), .period_width_p(12),
                   .dur_width_p(16), .gap_samples_p(0)) u_dut0 (
    .clk_i(clk_i), .reset_ni(reset_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i), .len_i(len_i), .loop_i(loop_i),
    .start_i(start_i), .stop_i(stop_i), .ready_i(ready_i), .data_o(data0),
    .valid_o(valid0), .busy_o(busy0), .step_o(step0), .done_o(done0));

  note_sequencer #(.width_p(12), .steps_p(16), .period_width_p(12),
                   .dur_width_p(16), .gap_samples_p(2)) u_dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i), .len_i(len_i), .loop_i(loop_i),
    .start_i(start_i), .stop_i(stop_i), .ready_i(ready_i), .data_o(data2),
    .valid_o(valid2), .busy_o(busy2), .step_o(step2), .done_o(done2));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_step(input int addr, input int p, input int d);
    wr_en_i     = 1'b1;
    wr_addr_i   = 4'(addr);
    wr_period_i = 12'(p);
    wr_dur_i    = 16'(d);
    tick();
    wr_en_i     = 1'b0;
  endtask

  task automatic start_seq(input int len, input logic lp);
    len_i   = 5'(len);
    loop_i  = lp;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic stop_all();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  function automatic int sq4(input int k);
    return ((k % 4) < 2) ? 2047 : -2047;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, done_cnt;
    logic prev_ready;
    logic signed [31:0] prev_data;
    int exp3 [12] = '{2047, -2047, 2047, 0, 0, 0, 0, 0, 0, 2047, 0, 0};
    int stp3 [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
    int exp5 [10] = '{2047, 2047, -2047, -2047, 0, 0, 2047, 2047, 2047, 2047};

    reset_ni = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_period_i = '0; wr_dur_i = '0;
    len_i = '0; loop_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
    #2;
    check("rst_valid", valid0, 0);
    check("rst_data", $signed(data0), 0);
    check("rst_busy", busy0, 0);
    check("rst_step", step0, 0);
    check("rst_done", done0, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    check("valid_up", valid0, 1);

    // Single note P=4 D=8
    write_step(0, 4, 8);
    start_seq(1, 1'b0);
    check("t1_busy", busy0, 1);
    check("t1_step", step0, 0);
    for (int i = 0; i < 8; i++) begin
      check("t1_data", $signed(data0), sq4(i));
      tick();
    end
    check("t1_done", done0, 1);
    check("t1_busy_low", busy0, 0);
    check("t1_idle_data", $signed(data0), 0);
    tick();
    check("t1_done_pulse", done0, 0);
    stop_all();

    // Same program with ready toggling
    start_seq(1, 1'b0);
    k = 0; prev_ready = 1'b1; prev_data = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      ready_i = (cyc % 2) == 1;
      if (!prev_ready) check("t2_hold", $signed(data0), prev_data);
      if (ready_i) begin
        check("t2_data", $signed(data0), sq4(k));
        k++;
      end
      prev_ready = ready_i;
      prev_data  = $signed(data0);
      tick();
    end
    ready_i = 1'b1;
    check("t2_count", k, 8);
    check("t2_done", done0, 1);
    stop_all();

    // Three steps with gaps on the gap instance
    write_step(0, 2, 3);
    write_step(1, 0, 2);
    write_step(2, 6, 0);
    start_seq(3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("t3_data", $signed(data2), exp3[i]);
      check("t3_step", step2, stp3[i]);
      check("t3_nodone", done2, 0);
      tick();
    end
    check("t3_done", done2, 1);
    check("t3_busy_low", busy2, 0);
    stop_all();

    // Loop over two steps, stop after 20 handshakes
    start_seq(2, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      int pos;
      pos = i % 5;
      check("t4_step", step0, (pos < 3) ? 0 : 1);
      check("t4_data", $signed(data0), (pos == 1) ? -2047 : ((pos < 3) ? 2047 : 0));
      if (done0) done_cnt++;
      tick();
    end
    stop_all();
    check("t4_busy", busy0, 0);
    check("t4_data_idle", $signed(data0), 0);
    check("t4_done", done0, 0);
    check("t4_done_cnt", done_cnt, 0);

    // Write to step 0 in the start cycle
    write_step(0, 4, 4);
    write_step(1, 0, 2);
    wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_period_i = 12'd8; wr_dur_i = 16'd4;
    len_i = 5'd2; loop_i = 1'b1; start_i = 1'b1;
    tick();
    wr_en_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_data", $signed(data0), exp5[i]);
      tick();
    end
    stop_all();

    // Asynchronous reset mid-note, then start with len 0
    write_step(0, 8, 4);
    start_seq(1, 1'b0);
    tick();
    tick();
    check("t6_pre", $signed(data0), 2047);
    #2;
    reset_ni = 1'b0;
    #1;
    check("t6_valid", valid0, 0);
    check("t6_data", $signed(data0), 0);
    check("t6_busy", busy0, 0);
    check("t6_busy2", busy2, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    start_seq(0, 1'b0);
    check("t6_len0_busy", busy0, 0);
    check("t6_len0_data", $signed(data0), 0);
    check("t6_valid_up", valid0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a programmed melody as a stream of signed square-wave samples. A small step memory holds per-note period and duration, both counted in samples. A state machine walks the steps, pacing every sample on a valid/ready handshake with the downstream audio sink (mixer or DAC serializer). It replaces fixed-pitch free-running tone generators wherever a timed sequence of notes, rests and gaps is needed.

## Interface
- width_p, 12, sample width (two's complement)
- steps_p, 16, number of step-memory entries
- period_width_p, 12, width of note period field (samples per cycle)
- dur_width_p, 16, width of note duration field (samples)
- gap_samples_p, 0, silent samples inserted after every note (0 = no gap)
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- wr_en_i  in  1  step-memory write strobe
- wr_addr_i  in  $clog2(steps_p)  step index to write
- wr_period_i  in  period_width_p  note period P (0 = rest)
- wr_dur_i  in  dur_width_p  note duration D
- len_i  in  $clog2(steps_p)+1  number of steps to play, sampled at start
- loop_i  in  1  repeat from step 0 after the last step, sampled at start
- start_i  in  1  begin playback (honoured in IDLE only)
- stop_i  in  1  abort playback
- ready_i  in  1  sink accepts data_o this cycle
- data_o  out  width_p  signed sample
- valid_o  out  1  data_o valid
- busy_o  out  1  state is not IDLE
- step_o  out  $clog2(steps_p)  index of the step being played
- done_o  out  1  one-cycle pulse at normal sequence completion

## Operation
- States: IDLE, NOTE, GAP.
- Handshake (hs) = valid_o & ready_i. All counters advance only on hs.
- A = 2^(width_p-1)-1. For width_p=12, A = 2047.
- Step memory:
  - Write-only from the port; writes are accepted in any state.
  - Writes are not cleared by reset; contents are undefined until written.
- IDLE:
  - data_o=0.
  - start_i with len_i≠0 and stop_i=0: latch len_i and loop_i, step=0, load the step, enter NOTE.
  - start_i with len_i=0: ignored.
  - len_i > steps_p is clamped to steps_p.
- Step load:
  - Latch P and D from memory. D=0 is treated as 1.
  - Clear phase ph and duration count dc.
  - Memory is read-before-write: a same-cycle write to the loaded step takes effect on the next load.
- NOTE sample value:
  - P=0: data_o=0.
  - Otherwise +A when ph < floor(P/2), else -A. P=1 therefore gives -A constantly.
- NOTE on hs:
  - ph advances and wraps P-1→0.
  - dc increments.
  - At the hs where dc reaches D: enter GAP if gap_samples_p>0, else advance the step.
- GAP:
  - data_o=0.
  - Advance the step after gap_samples_p hs.
- Step advance:
  - If step < len-1: step+1, load, NOTE.
  - Else if loop: step 0, load, NOTE.
  - Else: IDLE with done_o=1 for one cycle.
- stop_i (any state, highest priority):
  - IDLE next cycle, data_o=0, no done_o.
  - stop_i and start_i asserted together in IDLE: stays IDLE.
- Arithmetic:
  - ph is period_width_p bits; dc is dur_width_p bits.
  - A is width_p bits; -A is the two's complement.
  - No saturation paths are needed.

## Timing
- Reset values (asynchronous on reset_ni low): IDLE, valid_o=0, data_o=0, busy_o=0, step_o=0, done_o=0. All counters are 0.
- First rising edge after reset release: valid_o=1. It then stays 1 in every state until the next reset.
- All outputs are registered.
  - data_o reflects the current (state, ph). It changes only on the cycle after a hs, start or stop.
  - With ready_i=0, data_o and all counters hold.
- Start latency: start_i at edge n → NOTE, busy_o=1, step_o=0 and first sample at edge n+1.
- A note lasts exactly D handshakes. The first sample of the next step or gap appears on the cycle after the D-th hs.
- done_o rises on the cycle after the final hs of the last step (note or gap). busy_o falls in the same cycle.
- Reset asserted mid-note: outputs go to reset values immediately, with no clock required.

## Test plan
- P=4, D=8, len=1, gap=0, ready_i=1, start → data_o sequence 2047,2047,-2047,-2047 ×2. done_o on the cycle after the 8th hs. busy_o=0.
- Same program with ready_i toggled every other cycle → identical 8-sample sequence observed at hs only. data_o stable while ready_i=0.
- Steps {P=2,D=3},{P=0,D=2},{P=6,D=0} with gap_samples_p=2, len=3 → 2047,-2047,2047,0,0,0,0,0,0,2047,0,0, then done_o. step_o reads 0,1,2 at the matching samples.
- loop_i=1, len=2, stop_i after 20 hs → playback wraps step 1→0. IDLE the next cycle, data_o=0, done_o never pulses.
- Write step 0 to P=8 on the same cycle as start → first note uses the old P. On a loop pass, step 0 uses P=8.
- reset_ni pulled low mid-note without a clock edge → valid_o=0, data_o=0, busy_o=0 immediately. start_i ignored while len_i=0.
